apb_gpio_v2: RTL

APB_GPIO_V2 -- requirements
Module: apb_gpio_v2

---
 rtl/apb_gpio_v2.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/apb_gpio_v2.sv
// rtl/apb_gpio_v2.sv - APB GPIO block with per-pin debounce and interrupt status
//
// Ports:
//   HCLK, HRESET              clock, synchronous active-high reset
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE, PRDATA/PREADY/PSLVERR   APB slave
//   gpio_in                   asynchronous pad inputs
//   gpio_out, gpio_dir        pad output value and output enable (1 = drive)
//   interrupt                 level request, OR of the status register
module apb_gpio_v2 #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_GPIO       = 32,
    parameter int DEBOUNCE_W     = 8
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NUM_GPIO-1:0]       gpio_in,
    output logic [NUM_GPIO-1:0]       gpio_out,
    output logic [NUM_GPIO-1:0]       gpio_dir,
    output logic                      interrupt
);

    logic [NUM_GPIO-1:0]   r_dir, r_out, r_inten, r_type0, r_type1, r_stat, r_dben;
    logic [NUM_GPIO-1:0]   r_sync0, r_sync1, r_in;
    logic [DEBOUNCE_W-1:0] r_dbthr;
    logic [DEBOUNCE_W-1:0] r_cnt [NUM_GPIO];

    logic [3:0]            w_idx;
    logic                  w_err, w_wr;
    logic [NUM_GPIO-1:0]   w_wd, w_w1c, w_in_next, w_ev, w_stat_next;
    logic [DEBOUNCE_W-1:0] w_cnt_next [NUM_GPIO];
    logic                  w_unused;

    assign w_idx    = PADDR[5:2];
    assign w_err    = PSEL & PENABLE & (w_idx >= 4'hB);
    // Error accesses must not touch state, so they are excluded from the write strobe.
    assign w_wr     = PSEL & PENABLE & PWRITE & ~w_err;
    assign w_wd     = PWDATA[NUM_GPIO-1:0];
    assign w_w1c    = (w_wr && w_idx == 4'h8) ? w_wd : '0;
    assign w_unused = ^{PADDR[APB_ADDR_WIDTH-1:6], PADDR[1:0], PWDATA};

    assign PREADY    = 1'b1;
    assign PSLVERR   = w_err;
    assign gpio_out  = r_out;
    assign gpio_dir  = r_dir;
    assign interrupt = |r_stat;

    // Debounce: a pin only accepts a new synchronised level after it has
    // disagreed with the filtered value for DBTHR+1 consecutive samples.
    always_comb begin
        w_in_next = r_in;
        for (int i = 0; i < NUM_GPIO; i++) begin
            w_cnt_next[i] = '0;
            if (!r_dben[i]) begin
                w_in_next[i] = r_sync1[i];
            end else if (r_sync1[i] != r_in[i]) begin
                if (r_cnt[i] == r_dbthr) begin
                    w_in_next[i] = r_sync1[i];
                end else begin
                    w_cnt_next[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Events are judged against the value IN takes at this edge, so status
    // rises in the same cycle as the filtered input changes.
    assign w_ev = (~r_type1 & ~r_type0 &  w_in_next)
                | (~r_type1 &  r_type0 & ~w_in_next)
                | ( r_type1 & ~r_type0 &  w_in_next & ~r_in)
                | ( r_type1 &  r_type0 & ~w_in_next &  r_in);

    // Hardware set is OR-ed in after the clear, so it wins over a W1C.
    assign w_stat_next = (r_stat & ~w_w1c) | (r_inten & w_ev);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_dir   <= '0;
            r_out   <= '0;
            r_inten <= '0;
            r_type0 <= '0;
            r_type1 <= '0;
            r_stat  <= '0;
            r_dben  <= '0;
            r_dbthr <= '0;
            r_sync0 <= '0;
            r_sync1 <= '0;
            r_in    <= '0;
            for (int i = 0; i < NUM_GPIO; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync0 <= gpio_in;
            r_sync1 <= r_sync0;
            r_in    <= w_in_next;
            r_stat  <= w_stat_next;
            for (int i = 0; i < NUM_GPIO; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
            if (w_wr) begin
                case (w_idx)
                    4'h0:    r_dir   <= w_wd;
                    4'h2:    r_out   <= w_wd;
                    4'h3:    r_out   <= r_out | w_wd;
                    4'h4:    r_out   <= r_out & ~w_wd;
                    4'h5:    r_inten <= w_wd;
                    4'h6:    r_type0 <= w_wd;
                    4'h7:    r_type1 <= w_wd;
                    4'h9:    r_dbthr <= PWDATA[DEBOUNCE_W-1:0];
                    4'hA:    r_dben  <= w_wd;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        PRDATA = '0;
        case (w_idx)
            4'h0:    PRDATA[NUM_GPIO-1:0]   = r_dir;
            4'h1:    PRDATA[NUM_GPIO-1:0]   = r_in;
            4'h2:    PRDATA[NUM_GPIO-1:0]   = r_out;
            4'h5:    PRDATA[NUM_GPIO-1:0]   = r_inten;
            4'h6:    PRDATA[NUM_GPIO-1:0]   = r_type0;
            4'h7:    PRDATA[NUM_GPIO-1:0]   = r_type1;
            4'h8:    PRDATA[NUM_GPIO-1:0]   = r_stat;
            4'h9:    PRDATA[DEBOUNCE_W-1:0] = r_dbthr;
            4'hA:    PRDATA[NUM_GPIO-1:0]   = r_dben;
            default: PRDATA = '0;
        endcase
    end

endmodule
